// File: rtl/pipeline_stall_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and constants for the pipeline stall/flush
//                sequencer: FSM state enum, state width and the x0 register
//                index (x0 is hard-wired to zero and never creates a hazard).
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int         STATE_W = 2;
    localparam logic [4:0] REG_X0  = 5'd0;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_controller_load_use_compare.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_compare
//  Description : Combinational load-use hazard detector. Flags a hazard when
//                the EX instruction is a load whose destination (other than
//                x0) is a source register actually read by the ID instruction.
//  Ports       : id_rs1/id_rs2       - ID source registers
//                id_uses_rs1/_rs2    - ID instruction reads rs1/rs2
//                ex_rd               - EX destination register
//                ex_mem_read         - EX instruction is a load
//                hazard              - load-use match this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module load_use_compare
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       hazard
);

    logic w_rs1_match;
    logic w_rs2_match;

    assign w_rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    assign w_rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

    assign hazard = ex_mem_read && (ex_rd != REG_X0) && (w_rs1_match || w_rs2_match);

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_controller
//  Description : Central stall/flush sequencer for a 5-stage RISC-V pipeline.
//                Merges data-memory wait states, taken-branch flushes and
//                load-use hazards (priority in that order) into per-stage
//                write-enable and bubble controls. Outputs are Mealy.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                id_*/ex_rd/ex_mem_read     - load-use hazard inputs
//                ex_branch_taken            - taken branch/jump resolved in EX
//                mem_req/mem_ready          - data-memory handshake from MEM
//                pc/ifid/idex/exmem enables - pipeline register load enables
//                ifid_flush/idex_bubble/memwb_bubble - NOP/bubble controls
//                stall_count                - saturating stalled-cycle total
//                mem_timeout                - sticky long-wait flag
//                state                      - FSM state for debug
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_LATENCY = 1,
    parameter int MEM_TIMEOUT  = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write_en,
    output logic        ifid_write_en,
    output logic        ifid_flush,
    output logic        idex_write_en,
    output logic        idex_bubble,
    output logic        exmem_write_en,
    output logic        memwb_bubble,
    output logic [15:0] stall_count,
    output logic        mem_timeout,
    output logic [STATE_W-1:0] state
);

    localparam int                WAIT_W       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX     = WAIT_W'(MEM_TIMEOUT);
    localparam logic [2:0]        STALL_RELOAD = 3'(LOAD_LATENCY - 1);

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_next;
    ctrl_state_t       r_ret_state;
    ctrl_state_t       w_ret_next;
    ctrl_state_t       w_eff_state;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_next;
    logic [15:0]       r_stall_count;
    logic              r_mem_timeout;
    logic              w_hazard;
    logic              w_mem_wait;

    load_use_compare u_load_use (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .hazard      (w_hazard)
    );

    assign w_mem_wait = mem_req && !mem_ready;

    // The cycle a memory wait releases behaves exactly like the saved state,
    // including its transition, so a wait adds only the low-ready cycles.
    assign w_eff_state = (r_state == ST_MEM_WAIT) ? r_ret_state : r_state;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        pc_write_en    = 1'b1;
        ifid_write_en  = 1'b1;
        ifid_flush     = 1'b0;
        idex_write_en  = 1'b1;
        idex_bubble    = 1'b0;
        exmem_write_en = 1'b1;
        memwb_bubble   = 1'b0;
        w_state_next   = r_state;
        w_ret_next     = r_ret_state;
        w_cnt_next     = r_cnt;

        if (w_mem_wait) begin
            // Full freeze of everything upstream of MEM/WB; the stall
            // counter is left untouched so STALL resumes where it stopped.
            pc_write_en    = 1'b0;
            ifid_write_en  = 1'b0;
            idex_write_en  = 1'b0;
            exmem_write_en = 1'b0;
            memwb_bubble   = 1'b1;
            if (r_state != ST_MEM_WAIT) begin
                w_ret_next = r_state;
            end
            w_state_next = ST_MEM_WAIT;
        end else begin
            case (w_eff_state)
                ST_STALL: begin
                    // EX holds a bubble here, so branch and hazard inputs
                    // carry no meaning and are ignored.
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    idex_bubble   = 1'b1;
                    if (r_cnt <= 3'd1) begin
                        w_state_next = ST_RUN;
                        w_cnt_next   = 3'd0;
                    end else begin
                        w_state_next = ST_STALL;
                        w_cnt_next   = r_cnt - 3'd1;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                    if (ex_branch_taken) begin
                        // The PC loads the target; the two younger
                        // instructions in IF/ID and ID are squashed.
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (w_hazard) begin
                        pc_write_en   = 1'b0;
                        ifid_write_en = 1'b0;
                        idex_bubble   = 1'b1;
                        if (LOAD_LATENCY > 1) begin
                            w_state_next = ST_STALL;
                            w_cnt_next   = STALL_RELOAD;
                        end
                    end
                end
            endcase
        end

        // Reset flushes every stage while letting all registers load.
        if (reset) begin
            pc_write_en    = 1'b1;
            ifid_write_en  = 1'b1;
            ifid_flush     = 1'b1;
            idex_write_en  = 1'b1;
            idex_bubble    = 1'b1;
            exmem_write_en = 1'b1;
            memwb_bubble   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_ret_state <= ST_RUN;
            r_cnt       <= 3'd0;
        end else begin
            r_state     <= w_state_next;
            r_ret_state <= w_ret_next;
            r_cnt       <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Wait-length, timeout and stall statistics
    // ------------------------------------------------------------------
    always_comb begin
        w_wait_next = '0;
        if (w_mem_wait) begin
            w_wait_next = (r_wait_cnt == WAIT_MAX) ? WAIT_MAX : (r_wait_cnt + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_count <= 16'd0;
        end else begin
            r_wait_cnt <= w_wait_next;
            if (w_mem_wait && (w_wait_next == WAIT_MAX)) begin
                r_mem_timeout <= 1'b1;
            end
            if (!pc_write_en && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign mem_timeout = r_mem_timeout;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_stall_controller
//  Description : Self-checking bench. Two controller instances (LOAD_LATENCY=1
//                / MEM_TIMEOUT=256 and LOAD_LATENCY=3 / MEM_TIMEOUT=8) share
//                one stimulus stream; a cycle-level reference model tracks the
//                owed stall cycles, wait runs and statistics for each.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;

    // Control vector bit order:
    // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble}
    localparam logic [6:0] V_IDLE  = 7'b1101010;
    localparam logic [6:0] V_STALL = 7'b0001110;
    localparam logic [6:0] V_BR    = 7'b1111110;
    localparam logic [6:0] V_FRZ   = 7'b0000001;
    localparam logic [6:0] V_RST   = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;

    logic        a_pc, a_ifid, a_flush, a_idexwe, a_bub, a_exmem, a_mwb, a_to;
    logic [15:0] a_sc;
    logic [1:0]  a_st;
    logic        b_pc, b_ifid, b_flush, b_idexwe, b_bub, b_exmem, b_mwb, b_to;
    logic [15:0] b_sc;
    logic [1:0]  b_st;
    logic [6:0]  a_vec, b_vec;

    assign a_vec = {a_pc, a_ifid, a_flush, a_idexwe, a_bub, a_exmem, a_mwb};
    assign b_vec = {b_pc, b_ifid, b_flush, b_idexwe, b_bub, b_exmem, b_mwb};

    pipeline_stall_controller #(.LOAD_LATENCY(1), .MEM_TIMEOUT(256)) u_ll1 (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write_en(a_pc), .ifid_write_en(a_ifid), .ifid_flush(a_flush),
        .idex_write_en(a_idexwe), .idex_bubble(a_bub), .exmem_write_en(a_exmem),
        .memwb_bubble(a_mwb), .stall_count(a_sc), .mem_timeout(a_to), .state(a_st)
    );

    pipeline_stall_controller #(.LOAD_LATENCY(3), .MEM_TIMEOUT(8)) u_ll3 (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write_en(b_pc), .ifid_write_en(b_ifid), .ifid_flush(b_flush),
        .idex_write_en(b_idexwe), .idex_bubble(b_bub), .exmem_write_en(b_exmem),
        .memwb_bubble(b_mwb), .stall_count(b_sc), .mem_timeout(b_to), .state(b_st)
    );

    // ------------------------------------------------------------------
    // Reference model: "owed" is the number of further stall cycles still
    // owed to an earlier load-use hazard; waits never consume them.
    // ------------------------------------------------------------------
    typedef struct packed {
        int owed;
        bit prev_wait;
        int wait_run;
        int stall_cnt;
        bit tmo;
    } mst_t;

    typedef struct packed {
        logic [6:0]  vec;
        logic [1:0]  st;
        logic [15:0] sc;
        logic        tmo;
    } exp_t;

    mst_t ma, mb;
    int   checks = 0;
    int   passed = 0;

    function automatic void model(input mst_t s, input int ll, input int lim,
                                  output exp_t e, output mst_t ns);
        bit mw, hz;
        mw = mem_req && !mem_ready;
        hz = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        e.vec = V_IDLE;
        e.st  = s.prev_wait ? 2'd2 : ((s.owed > 0) ? 2'd1 : 2'd0);
        e.sc  = s.stall_cnt[15:0];
        e.tmo = s.tmo;
        ns    = s;
        if (reset) begin
            e.vec = V_RST;
            ns    = '0;
        end else if (mw) begin
            e.vec        = V_FRZ;
            ns.prev_wait = 1'b1;
            ns.wait_run  = s.wait_run + 1;
            if (ns.wait_run >= lim) ns.tmo = 1'b1;
        end else begin
            ns.prev_wait = 1'b0;
            ns.wait_run  = 0;
            if (s.owed > 0) begin
                e.vec   = V_STALL;
                ns.owed = s.owed - 1;
            end else if (ex_branch_taken) begin
                e.vec = V_BR;
            end else if (hz) begin
                e.vec   = V_STALL;
                ns.owed = ll - 1;
            end
        end
        if (!reset && !e.vec[6] && s.stall_cnt < 65535) ns.stall_cnt = s.stall_cnt + 1;
    endfunction

    task automatic tick();
        exp_t e;
        mst_t n;
        @(posedge clk);
        model(ma, 1, 256, e, n); ma = n;
        model(mb, 3, 8, e, n);   mb = n;
        #1;
    endtask

    task automatic set_idle();
        reset = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    // lw x3 in EX, add x5,x3,x4 in ID
    task automatic set_hz();
        set_idle();
        ex_mem_read = 1'b1; ex_rd = 5'd3;
        id_rs1 = 5'd3; id_rs2 = 5'd4; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    endtask

    task automatic pulse_reset();
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (a_vec !== V_RST) $display("FAIL reset_vec_ll1: got %b want %b", a_vec, V_RST); else passed++;
        checks++; if (b_vec !== V_RST) $display("FAIL reset_vec_ll3: got %b want %b", b_vec, V_RST); else passed++;
        checks++; if (b_st !== 2'd0) $display("FAIL reset_state: got %0d want 0", b_st); else passed++;
        checks++; if (b_sc !== 16'd0 || a_sc !== 16'd0) $display("FAIL reset_stall_count: got %0d/%0d want 0", a_sc, b_sc); else passed++;
        checks++; if (b_to !== 1'b0) $display("FAIL reset_timeout: got %b want 0", b_to); else passed++;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (a_vec !== V_IDLE) $display("FAIL idle_vec: got %b want %b", a_vec, V_IDLE); else passed++;
        tick();
    endtask

    task automatic test_load_use();
        logic [6:0] exp_a [4];
        logic [6:0] exp_b [4];
        logic [1:0] exp_s [4];
        exp_a = '{V_STALL, V_IDLE, V_IDLE, V_IDLE};
        exp_b = '{V_STALL, V_STALL, V_STALL, V_IDLE};
        exp_s = '{2'd0, 2'd1, 2'd1, 2'd0};
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) set_hz(); else set_idle();
            @(negedge clk);
            checks++; if (a_vec !== exp_a[i]) $display("FAIL lu_ll1_vec c%0d: got %b want %b", i, a_vec, exp_a[i]); else passed++;
            checks++; if (b_vec !== exp_b[i]) $display("FAIL lu_ll3_vec c%0d: got %b want %b", i, b_vec, exp_b[i]); else passed++;
            checks++; if (b_st !== exp_s[i]) $display("FAIL lu_ll3_state c%0d: got %0d want %0d", i, b_st, exp_s[i]); else passed++;
            tick();
        end
        @(negedge clk);
        checks++; if (a_sc !== 16'd1) $display("FAIL lu_ll1_count: got %0d want 1", a_sc); else passed++;
        checks++; if (b_sc !== 16'd3) $display("FAIL lu_ll3_count: got %0d want 3", b_sc); else passed++;
        tick();
    endtask

    task automatic test_no_hazard();
        set_hz();
        ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        @(negedge clk);
        checks++; if (a_vec !== V_IDLE) $display("FAIL x0_no_stall: got %b want %b", a_vec, V_IDLE); else passed++;
        tick();
        set_hz();
        ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b0; id_rs2 = 5'd6;
        @(negedge clk);
        checks++; if (b_vec !== V_IDLE) $display("FAIL unused_rs1_no_stall: got %b want %b", b_vec, V_IDLE); else passed++;
        tick();
    endtask

    task automatic test_branch();
        pulse_reset();
        set_hz();
        ex_branch_taken = 1'b1;
        @(negedge clk);
        checks++; if (a_vec !== V_BR) $display("FAIL br_ll1_vec: got %b want %b", a_vec, V_BR); else passed++;
        checks++; if (b_vec !== V_BR) $display("FAIL br_ll3_vec: got %b want %b", b_vec, V_BR); else passed++;
        tick();
        set_idle();
        @(negedge clk);
        checks++; if (b_st !== 2'd0) $display("FAIL br_no_stall_state: got %0d want 0", b_st); else passed++;
        checks++; if (b_sc !== 16'd0) $display("FAIL br_no_stall_count: got %0d want 0", b_sc); else passed++;
        tick();
    endtask

    task automatic test_mem_wait_in_stall();
        logic [6:0] exp_v [8];
        logic [1:0] exp_s [8];
        exp_v = '{V_STALL, V_STALL, V_FRZ, V_FRZ, V_FRZ, V_FRZ, V_STALL, V_IDLE};
        exp_s = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) set_hz(); else set_idle();
            if (i >= 2 && i <= 6) begin
                mem_req   = 1'b1;
                mem_ready = (i == 6);
            end
            @(negedge clk);
            checks++; if (b_vec !== exp_v[i]) $display("FAIL mw_vec c%0d: got %b want %b", i, b_vec, exp_v[i]); else passed++;
            checks++; if (b_st !== exp_s[i]) $display("FAIL mw_state c%0d: got %0d want %0d", i, b_st, exp_s[i]); else passed++;
            tick();
        end
        @(negedge clk);
        checks++; if (b_sc !== 16'd7) $display("FAIL mw_count: got %0d want 7", b_sc); else passed++;
        tick();
    endtask

    task automatic test_timeout();
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            set_idle();
            mem_req = 1'b1; mem_ready = 1'b0;
            @(negedge clk);
            checks++; if (b_to !== (i >= 8)) $display("FAIL timeout c%0d: got %b want %b", i, b_to, (i >= 8)); else passed++;
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            set_idle();
            @(negedge clk);
            checks++; if (b_to !== 1'b1) $display("FAIL timeout_sticky c%0d: got %b want 1", i, b_to); else passed++;
            checks++; if (a_to !== 1'b0) $display("FAIL timeout_ll1 c%0d: got %b want 0", i, a_to); else passed++;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            set_idle();
            mem_req = 1'b1; mem_ready = 1'b0;
            tick();
        end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (b_vec !== V_RST) $display("FAIL reset_mid_wait_vec: got %b want %b", b_vec, V_RST); else passed++;
        tick();
        set_idle();
        @(negedge clk);
        checks++; if (b_st !== 2'd0) $display("FAIL reset_mid_wait_state: got %0d want 0", b_st); else passed++;
        checks++; if (b_sc !== 16'd0) $display("FAIL reset_mid_wait_count: got %0d want 0", b_sc); else passed++;
        checks++; if (b_to !== 1'b0) $display("FAIL reset_mid_wait_timeout: got %b want 0", b_to); else passed++;
        tick();
    endtask

    task automatic test_random();
        exp_t ea, eb;
        mst_t n;
        for (int i = 0; i < 600; i++) begin
            reset           = ($urandom_range(0, 39) == 0);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            mem_req         = ($urandom_range(0, 2) == 0);
            mem_ready       = 1'($urandom_range(0, 1));
            @(negedge clk);
            model(ma, 1, 256, ea, n);
            model(mb, 3, 8, eb, n);
            checks++; if (a_vec !== ea.vec) $display("FAIL rnd_ll1_vec c%0d: got %b want %b", i, a_vec, ea.vec); else passed++;
            checks++; if (a_st !== ea.st) $display("FAIL rnd_ll1_state c%0d: got %0d want %0d", i, a_st, ea.st); else passed++;
            checks++; if (a_sc !== ea.sc) $display("FAIL rnd_ll1_count c%0d: got %0d want %0d", i, a_sc, ea.sc); else passed++;
            checks++; if (a_to !== ea.tmo) $display("FAIL rnd_ll1_timeout c%0d: got %b want %b", i, a_to, ea.tmo); else passed++;
            checks++; if (b_vec !== eb.vec) $display("FAIL rnd_ll3_vec c%0d: got %b want %b", i, b_vec, eb.vec); else passed++;
            checks++; if (b_st !== eb.st) $display("FAIL rnd_ll3_state c%0d: got %0d want %0d", i, b_st, eb.st); else passed++;
            checks++; if (b_sc !== eb.sc) $display("FAIL rnd_ll3_count c%0d: got %0d want %0d", i, b_sc, eb.sc); else passed++;
            checks++; if (b_to !== eb.tmo) $display("FAIL rnd_ll3_timeout c%0d: got %b want %b", i, b_to, eb.tmo); else passed++;
            tick();
        end
    endtask

    initial begin
        ma = '0;
        mb = '0;
        set_idle();
        reset = 1'b1;
        #1;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_mem_wait_in_stall();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It combines three hazard sources into one consistent set of per-stage write-enable and bubble controls:
- load-use hazards, with a configurable stall length;
- taken-branch flushes resolved in EX;
- data-memory wait states from MEM.

It sits beside the register file and drives the PC register and all four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- LOAD_LATENCY, 1 — stall cycles inserted per load-use hazard (1..7).
- MEM_TIMEOUT, 256 — consecutive MEM_WAIT cycles before `mem_timeout` is raised.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- mem_req  in  1  MEM instruction accesses data memory this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write_en  out  1  PC register load enable.
- ifid_write_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_write_en  out  1  ID/EX register load enable.
- idex_bubble  out  1  ID/EX control fields are zeroed (bubble).
- exmem_write_en  out  1  EX/MEM register load enable.
- memwb_bubble  out  1  MEM/WB control fields are zeroed.
- stall_count  out  16  saturating total of stalled cycles (STALL + MEM_WAIT).
- mem_timeout  out  1  sticky flag: memory wait exceeded MEM_TIMEOUT.
- state  out  2  current FSM state, for debug.

## Operation
- States: RUN=0, STALL=1, MEM_WAIT=2.
- Outputs are Mealy: they are computed from the current state and inputs in the same cycle.
- Default (no event): all write enables are 1; `ifid_flush`, `idex_bubble` and `memwb_bubble` are 0.
- Load-use condition:
  - `ex_mem_read` && `ex_rd`≠0 && ((`id_uses_rs1` && `id_rs1`==`ex_rd`) || (`id_uses_rs2` && `id_rs2`==`ex_rd`)).
  - x0 never causes a hazard.
- Priority in every state: memory wait > branch > load-use.
- Memory wait (`mem_req` && !`mem_ready`):
  - pc, ifid, idex and exmem write enables are all 0; `memwb_bubble`=1.
  - The current state (RUN or STALL) is saved as the return state; go to MEM_WAIT.
- MEM_WAIT:
  - Outputs are identical to the memory-wait outputs while `mem_ready`=0.
  - The cycle `mem_ready`=1 (or `mem_req`=0) uses normal outputs for the saved state, and the FSM returns to that state.
  - The STALL counter is frozen throughout.
- Branch (RUN only):
  - `ifid_flush`=1 and `idex_bubble`=1; `pc_write_en`=1 so the PC loads the target.
  - Any load-use condition in that cycle is ignored.
- Load-use in RUN:
  - `pc_write_en`=0, `ifid_write_en`=0, `idex_bubble`=1.
  - If LOAD_LATENCY>1: load cnt=LOAD_LATENCY-1 and go to STALL; otherwise stay in RUN.
- STALL:
  - Same outputs as load-use; the hazard inputs are ignored.
  - cnt decrements each non-frozen cycle; at cnt==1 go to RUN.
  - `ex_branch_taken` is ignored, because EX holds a bubble.
- `stall_count` increments on every cycle with `pc_write_en`=0 and saturates at 16'hFFFF.
- `mem_timeout` is set when the wait counter reaches MEM_TIMEOUT. It is cleared only by reset. The wait counter clears on leaving MEM_WAIT.

## Timing
- Reset (sampled at a clk edge):
  - state=RUN, cnt=0, `stall_count`=0, `mem_timeout`=0.
  - While `reset`=1, outputs are forced: all write enables 1, and `ifid_flush`, `idex_bubble`, `memwb_bubble` all 1.
  - Reset mid-STALL or mid-MEM_WAIT aborts to RUN on the next edge.
- Latency:
  - Each load-use hazard costs exactly LOAD_LATENCY cycles.
  - A branch costs 2 squashed instructions in 1 cycle.
  - A memory wait stalls exactly as many cycles as `mem_ready` stays low.
- Simultaneous events:
  - A memory wait together with a branch: the branch is honoured on the first non-waiting cycle, because EX is held and re-presents it.
  - A memory wait arising in STALL resumes STALL with the same cnt.

## Structure
- `pipe_ctrl_pkg`: state enum (RUN/STALL/MEM_WAIT), the 2-bit state width and the x0 register constant.
- Sub-module `load_use_compare`: the purely combinational load-use match, instantiated once.
- The FSM, counters and output decode live in the top level.

## Test plan
- ID `add x5,x3,x4` follows `lw x3` in EX, LOAD_LATENCY=1 → one cycle with `pc_write_en`=0, `ifid_write_en`=0, `idex_bubble`=1; `stall_count`=1.
- LOAD_LATENCY=3, same hazard → exactly 3 stall cycles; `state` sequence RUN, STALL, STALL, RUN; `stall_count`=3.
- `lw x0` with rs1=0, and a separate case with a matching rd but `id_uses_rs1`=0 → no stall.
- `ex_branch_taken`=1 while a load-use condition is also true → `ifid_flush`=1, `idex_bubble`=1, `pc_write_en`=1, no stall.
- `mem_req`=1 with `mem_ready` low for 4 cycles during the second STALL cycle → 4 full-freeze cycles with `memwb_bubble`=1; the FSM then resumes STALL for the remaining stall cycle; `stall_count`=7.
- MEM_TIMEOUT=8 with `mem_ready` held low for 10 cycles → `mem_timeout` rises after 8 cycles and stays 1 until reset; reset mid-wait → state=RUN, `stall_count`=0.
